// File: rtl/sprite_draw_engine_if.sv
// Command and frame-buffer write bundle between the game controller (master)
// and sprite_draw_engine (slave).
interface sprite_draw_engine_if #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [X_W-1:0] x_origin;
  logic [Y_W-1:0] y_origin;
  logic           pose;
  logic           plot;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     color;
  logic           done;
  logic           busy;

  modport master (
    output cmd_valid, cmd_op, x_origin, y_origin, pose,
    input  cmd_ready, plot, x, y, color, done, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, x_origin, y_origin, pose,
    output cmd_ready, plot, x, y, color, done, busy
  );
endinterface

// File: rtl/sprite_draw_engine.sv
// Pixel-plotting engine for the 160x120 3-bit frame buffer: floors, sprite
// draw/erase with clipping, and clear screen, one frame-buffer write per cycle.
module sprite_draw_engine #(
  parameter int unsigned X_W         = 8,
  parameter int unsigned Y_W         = 7,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned FLOOR_COUNT = 3,
  parameter int unsigned FLOOR_Y0    = 35,
  parameter int unsigned FLOOR_PITCH = 40,
  parameter int unsigned FLOOR_THICK = 5,
  parameter int unsigned SPR_W       = 8,
  parameter int unsigned SPR_H       = 8,
  parameter logic [SPR_W*SPR_H-1:0] SPR_NORMAL = 64'h6642_3C18_3C5A_3C18,
  parameter logic [SPR_W*SPR_H-1:0] SPR_CROUCH = 64'h6642_7EFF_3C18_0000,
  parameter logic [2:0]  FG_COLOR    = 3'b111,
  parameter logic [2:0]  FLOOR_COLOR = 3'b101,
  parameter logic [2:0]  BG_COLOR    = 3'b000
) (
  input  logic              clk,
  input  logic              reset_n,
  sprite_draw_engine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FLOORS, SPRITE, CLEAR, DONE} state_t;

  localparam int unsigned IDX_W = $clog2(SPR_W*SPR_H);

  localparam logic [X_W-1:0] SCR_COL_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] SCR_ROW_LAST = Y_W'(SCREEN_H - 1);
  localparam logic [X_W-1:0] SPR_COL_LAST = X_W'(SPR_W - 1);
  localparam logic [Y_W-1:0] SPR_ROW_LAST = Y_W'(SPR_H - 1);
  localparam logic [Y_W-1:0] THICK_LAST   = Y_W'(FLOOR_THICK - 1);
  localparam logic [7:0]     FLOOR_LAST   = 8'(FLOOR_COUNT - 1);
  localparam logic [15:0]    FLOOR_TOP    = 16'(FLOOR_Y0);
  localparam logic [15:0]    PITCH16      = 16'(FLOOR_PITCH);
  localparam logic [15:0]    SCR_H16      = 16'(SCREEN_H);
  localparam logic [X_W:0]   SCR_W_X      = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   SCR_H_Y      = (Y_W+1)'(SCREEN_H);

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [X_W-1:0] xo_q, xo_d;
  logic [Y_W-1:0] yo_q, yo_d;
  logic           pose_q, pose_d;
  logic [X_W-1:0] col_q, col_d;
  logic [Y_W-1:0] row_q, row_d;
  logic [7:0]     fidx_q, fidx_d;
  logic [15:0]    fbase_q, fbase_d;

  logic           plot_q, plot_d;
  logic [X_W-1:0] x_q, px;
  logic [Y_W-1:0] y_q, py;
  logic [2:0]     color_q, pc;

  logic [X_W:0]             xs;
  logic [Y_W:0]             ys;
  logic [15:0]              fy;
  logic [SPR_W*SPR_H-1:0]   bitmap;
  logic [IDX_W-1:0]         idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      pose_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      fidx_q  <= '0;
      fbase_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      pose_q  <= pose_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fidx_q  <= fidx_d;
      fbase_q <= fbase_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    op_d    = op_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    pose_d  = pose_q;
    col_d   = col_q;
    row_d   = row_q;
    fidx_d  = fidx_q;
    fbase_d = fbase_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          xo_d    = bus.x_origin;
          yo_d    = bus.y_origin;
          pose_d  = bus.pose;
          col_d   = '0;
          row_d   = '0;
          fidx_d  = '0;
          fbase_d = FLOOR_TOP;
          unique case (bus.cmd_op)
            2'b00:   state_d = FLOORS;
            2'b11:   state_d = CLEAR;
            default: state_d = SPRITE;
          endcase
        end
      end
      FLOORS: begin
        if (col_q == SCR_COL_LAST) begin
          col_d = '0;
          if (row_q == THICK_LAST) begin
            row_d = '0;
            if (fidx_q == FLOOR_LAST) begin
              state_d = DONE;
            end else begin
              fidx_d  = fidx_q + 8'd1;
              fbase_d = fbase_q + PITCH16;
            end
          end else begin
            row_d = row_q + Y_W'(1);
          end
        end else begin
          col_d = col_q + X_W'(1);
        end
      end
      SPRITE: begin
        if (col_q == SPR_COL_LAST) begin
          col_d = '0;
          if (row_q == SPR_ROW_LAST) state_d = DONE;
          else                       row_d   = row_q + Y_W'(1);
        end else begin
          col_d = col_q + X_W'(1);
        end
      end
      CLEAR: begin
        if (col_q == SCR_COL_LAST) begin
          col_d = '0;
          if (row_q == SCR_ROW_LAST) state_d = DONE;
          else                       row_d   = row_q + Y_W'(1);
        end else begin
          col_d = col_q + X_W'(1);
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  // Pixel is derived from the next scan position so the registered write
  // lands on the cycle right after acceptance.
  always_comb begin : pixel
    xs     = {1'b0, xo_d} + {1'b0, col_d};
    ys     = {1'b0, yo_d} + {1'b0, row_d};
    fy     = fbase_d + 16'(row_d);
    bitmap = pose_d ? SPR_NORMAL : SPR_CROUCH;
    idx    = IDX_W'(row_d) * IDX_W'(SPR_W) + IDX_W'(col_d);
    plot_d = 1'b0;
    px     = col_d;
    py     = row_d;
    pc     = BG_COLOR;
    unique case (state_d)
      FLOORS: begin
        plot_d = (fy < SCR_H16);
        py     = fy[Y_W-1:0];
        pc     = FLOOR_COLOR;
      end
      SPRITE: begin
        plot_d = bitmap[idx] && (xs < SCR_W_X) && (ys < SCR_H_Y);
        px     = xs[X_W-1:0];
        py     = ys[Y_W-1:0];
        pc     = (op_d == 2'b10) ? BG_COLOR : FG_COLOR;
      end
      CLEAR:      plot_d = 1'b1;
      IDLE, DONE: plot_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      plot_q <= plot_d;
      if (plot_d) begin
        x_q     <= px;
        y_q     <= py;
        color_q <= pc;
      end
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.plot      = plot_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.color     = color_q;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine: floors, sprite draw/erase/clip,
// clear, mid-command reset and back-to-back commands.
module tb_sprite_draw_engine;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] NORM   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] CROUCH = 64'h8000_0000_0000_0001;

    sprite_draw_engine_if #(.X_W(8), .Y_W(7)) bus ();

    sprite_draw_engine #(
        .X_W(8), .Y_W(7), .SCREEN_W(160), .SCREEN_H(120),
        .FLOOR_COUNT(3), .FLOOR_Y0(35), .FLOOR_PITCH(40), .FLOOR_THICK(5),
        .SPR_W(8), .SPR_H(8), .SPR_NORMAL(NORM), .SPR_CROUCH(CROUCH),
        .FG_COLOR(3'b111), .FLOOR_COLOR(3'b101), .BG_COLOR(3'b000)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    logic [17:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected write list as {x, y, color}, generated from nested loops.
    task automatic build_exp(input logic [1:0] op, input int xo, input int yo, input logic p);
        logic [63:0] bm;
        int yy;
        exp_q.delete();
        bm = p ? NORM : CROUCH;
        case (op)
            2'b00:
                for (int f = 0; f < 3; f++)
                    for (int r = 0; r < 5; r++)
                        for (int c = 0; c < 160; c++) begin
                            yy = 35 + 40 * f + r;
                            if (yy < 120) exp_q.push_back({8'(c), 7'(yy), 3'b101});
                        end
            2'b11:
                for (int r = 0; r < 120; r++)
                    for (int c = 0; c < 160; c++)
                        exp_q.push_back({8'(c), 7'(r), 3'b000});
            default:
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        if (bm[r*8+c] && (xo + c) < 160 && (yo + r) < 120)
                            exp_q.push_back({8'(xo + c), 7'(yo + r), (op == 2'b10) ? 3'b000 : 3'b111});
        endcase
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] xo,
                           input logic [6:0] yo, input logic p, input int exp_plots,
                           input int exp_done, input bit hold, input bit exp_nowait);
        int w = 0;
        int plots = 0;
        int mism = 0;
        int busy_low = 0;
        int done_cyc = -1;
        build_exp(op, xo, yo, p);
        @(negedge clk);
        check({tag, "_done_single"}, bus.done, 1'b0);
        while (!bus.cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready_seen"}, (w < 100), 1'b1);
        if (exp_nowait) begin
            check({tag, "_gap_wait"}, w, 0);
            check({tag, "_gap_busy"}, bus.busy, 1'b0);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.x_origin  = xo;
        bus.y_origin  = yo;
        bus.pose      = p;
        @(posedge clk);
        for (int cyc = 1; cyc <= exp_done + 100 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (!hold) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_op    = ~op;
                bus.x_origin  = ~xo;
                bus.y_origin  = ~yo;
                bus.pose      = ~p;
            end
            if (!bus.busy) busy_low++;
            if (bus.done) begin
                done_cyc = cyc;
                check({tag, "_plot_at_done"}, bus.plot, 1'b0);
                check({tag, "_ready_at_done"}, bus.cmd_ready, 1'b0);
            end else if (bus.plot) begin
                if (plots >= exp_q.size() || {bus.x, bus.y, bus.color} !== exp_q[plots]) begin
                    if (mism == 0)
                        $display("first bad write in %s at index %0d: x=%0d y=%0d c=%0d",
                                 tag, plots, bus.x, bus.y, bus.color);
                    mism++;
                end
                plots++;
            end
        end
        check({tag, "_plots"}, plots, exp_plots);
        check({tag, "_pixel_mism"}, mism, 0);
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_busy_low"}, busy_low, 0);
    endtask

    initial begin
        int plots;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.x_origin  = '0;
        bus.y_origin  = '0;
        bus.pose      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_plot",  bus.plot, 1'b0);
        check("rst_x",     bus.x, 8'd0);
        check("rst_y",     bus.y, 7'd0);
        check("rst_color", bus.color, 3'd0);
        check("rst_done",  bus.done, 1'b0);
        check("rst_busy",  bus.busy, 1'b0);
        check("rst_ready", bus.cmd_ready, 1'b1);
        reset_n = 1'b1;

        run_cmd("floors", 2'b00, 8'd0,   7'd0,   1'b0, 2400,  2401,  1'b0, 1'b0);
        run_cmd("draw",   2'b01, 8'd10,  7'd20,  1'b1, 64,    65,    1'b0, 1'b0);
        run_cmd("erase",  2'b10, 8'd30,  7'd40,  1'b0, 2,     65,    1'b0, 1'b0);
        run_cmd("clip",   2'b01, 8'd156, 7'd116, 1'b1, 16,    65,    1'b0, 1'b0);
        run_cmd("offscr", 2'b01, 8'd200, 7'd10,  1'b1, 0,     65,    1'b0, 1'b0);
        run_cmd("clear",  2'b11, 8'd0,   7'd0,   1'b0, 19200, 19201, 1'b0, 1'b0);

        // Clear interrupted by reset after 500 pixel cycles.
        @(negedge clk);
        check("intr_ready", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        @(posedge clk);
        plots = 0;
        for (int cyc = 1; cyc <= 500; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (bus.plot) plots++;
        end
        check("intr_plots", plots, 500);
        reset_n = 1'b0;
        #1;
        check("intr_plot",  bus.plot, 1'b0);
        check("intr_busy",  bus.busy, 1'b0);
        check("intr_ready", bus.cmd_ready, 1'b1);
        check("intr_done",  bus.done, 1'b0);
        check("intr_x",     bus.x, 8'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("intr_post_done", bus.done, 1'b0);
        check("intr_post_plot", bus.plot, 1'b0);
        run_cmd("redraw", 2'b01, 8'd10, 7'd20, 1'b1, 64, 65, 1'b0, 1'b0);

        // cmd_valid held high across two commands.
        run_cmd("hold1", 2'b01, 8'd10, 7'd20, 1'b1, 64, 65, 1'b1, 1'b0);
        run_cmd("hold2", 2'b01, 8'd40, 7'd50, 1'b1, 64, 65, 1'b1, 1'b1);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_hold", bus.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
